// File: rtl/rx_fifo_if.sv
// Handshake bundle between the Rx shifter/host side and the rx_fifo byte buffer.
// The master side is the shifter plus host. The slave side is the FIFO itself.
interface rx_fifo_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]      wr_data;
    logic            wr_valid;
    logic            rd_en;
    logic            clr_overrun;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overrun;

    modport master (
        output wr_data, wr_valid, rd_en, clr_overrun,
        input  rd_data, rd_valid, empty, full, count, overrun
    );

    modport slave (
        input  wr_data, wr_valid, rd_en, clr_overrun,
        output rd_data, rd_valid, empty, full, count, overrun
    );
endinterface

// File: rtl/rx_fifo.sv
// Circular receive byte buffer fed by the Rx shifter's done strobe and drained by the host.
// The optional sticky overrun flag is built only when RX_FIFO_OVERRUN_EN is defined.
module rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input logic       clk,
    input logic       rst_n,
    rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W:0]   cnt;
    logic [7:0]        rd_data_q;
    logic              rd_valid_q;
    logic              is_full;
    logic              is_empty;
    logic              rd_acc;
    logic              wr_acc;

    assign is_full  = (cnt == DEPTH_C);
    assign is_empty = (cnt == '0);
    assign rd_acc   = bus.rd_en && !is_empty;
    // A write into a full FIFO can still land when a read frees a slot in the same cycle.
    assign wr_acc   = bus.wr_valid && (!is_full || rd_acc);

    // Storage is not reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wp <= wp + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_data_q <= mem[rp];
                rp        <= rp + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef RX_FIFO_OVERRUN_EN
    logic drop;
    logic overrun_q;

    assign drop = bus.wr_valid && is_full && !rd_acc;

    // A fresh drop beats a simultaneous clear so no lost byte goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.count    = cnt;
endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive byte buffer directly downstream of the USRT Rx shift register, in the `i_Pclk` domain. Each one-cycle byte-done strobe writes the shifter's 8-bit parallel word into a circular FIFO. The host side drains the FIFO with a read-enable / read-valid handshake. The buffer absorbs host latency so back-to-back frames are not lost.

## Interface
Parameters:
- `DEPTH`, default 8: number of byte entries; power of two, minimum 2.
- `ADDR_W`, default 3: pointer width; must equal log2(`DEPTH`).

Ports:
- `i_Pclk`  in  1  system clock; all logic is on the rising edge.
- `i_Rst_n`  in  1  reset, asynchronous and active-low.
- `i_Wr_Data`  in  8  byte from the Rx shifter; stable while `i_Wr_Valid` is high.
- `i_Wr_Valid`  in  1  one-cycle write strobe (the shifter's done pulse).
- `i_Rd_En`  in  1  host read request, one byte per high cycle.
- `o_Rd_Data`  out  8  registered read data.
- `o_Rd_Valid`  out  1  one-cycle pulse; `o_Rd_Data` is valid in this cycle.
- `o_Empty`  out  1  FIFO holds 0 entries.
- `o_Full`  out  1  FIFO holds `DEPTH` entries.
- `o_Count`  out  `ADDR_W`+1  current occupancy, 0..`DEPTH`.
- `o_Overrun`  out  1  sticky lost-byte flag (see Configuration).
- `i_Clr_Overrun`  in  1  clears `o_Overrun`.

## Operation
- Storage is `DEPTH` x 8 registers with write pointer `wp`, read pointer `rp` (`ADDR_W` bits) and count `cnt` (`ADDR_W`+1 bits).
- Both pointers wrap modulo `DEPTH` by natural overflow: `DEPTH`-1 goes to 0.
- Write accepted = `i_Wr_Valid` && (!full || read accepted in the same cycle).
  - On accept: `mem[wp]` <= `i_Wr_Data`, then `wp` increments.
- Read accepted = `i_Rd_En` && !empty.
  - On accept: `o_Rd_Data` <= `mem[rp]`, `rp` increments, `o_Rd_Valid` <= 1.
  - Otherwise `o_Rd_Valid` <= 0 and `o_Rd_Data` holds its last value.
- `cnt` update per cycle:
  - +1 for write only.
  - -1 for read only.
  - Unchanged for both or neither.
- `o_Empty` = (`cnt` == 0); `o_Full` = (`cnt` == `DEPTH`); `o_Count` = `cnt`. All are combinational from the `cnt` register.
- Boundary conditions:
  - Read while empty: ignored, no pointer change, `o_Rd_Valid` stays 0. There is no fall-through; a same-cycle write into an empty FIFO is not readable until the next cycle.
  - Write while full with no read: byte dropped, pointers and memory unchanged, overrun event raised.
  - Write and read in the same cycle while full: both accepted, `cnt` stays `DEPTH`, no overrun.
  - Write and read in the same cycle with 0 < `cnt` < `DEPTH`: both accepted, `cnt` unchanged.
- Reset (asynchronous, any time including mid-transfer):
  - `wp` = `rp` = 0, `cnt` = 0.
  - `o_Rd_Data` = 8'h00, `o_Rd_Valid` = 0, `o_Overrun` = 0.
  - Therefore `o_Empty` = 1, `o_Full` = 0, `o_Count` = 0.
  - Memory contents are not reset and are don't-care.
  - The first clock edge after deassertion behaves as normal operation.

## Timing
- Write-to-visible latency is 1 cycle: a strobe at edge N updates `o_Count`/`o_Empty` after edge N, and a read may be accepted at edge N+1.
- Read latency is 1 cycle: `i_Rd_En` sampled at edge N gives `o_Rd_Data`/`o_Rd_Valid` after edge N.
- Sustained throughput is one read per cycle. The host may hold `i_Rd_En` high; reads stop automatically when the FIFO is empty.
- `i_Wr_Valid` held high for k cycles is treated as k writes. The upstream shifter guarantees single-cycle pulses.

## Configuration
- Macro: `RX_FIFO_OVERRUN_EN`.
- Defined:
  - `o_Overrun` is set on the cycle after a dropped write.
  - It stays set until `i_Clr_Overrun` is sampled high.
  - If a set event and a clear occur in the same cycle, the set wins and `o_Overrun` stays 1.
- Undefined:
  - The overrun register is not built and `o_Overrun` is tied to 0.
  - `i_Clr_Overrun` is ignored.
  - Drop-on-full behaviour is unchanged.

## Test plan
- Reset mid-traffic: fill 3 bytes, assert `i_Rst_n`=0 asynchronously between clock edges → outputs immediately read `o_Count`=0, `o_Empty`=1, `o_Rd_Valid`=0, `o_Rd_Data`=8'h00.
- Ordering: write 8'hA5, 8'h3C, 8'hFF, then read 3 times → `o_Rd_Valid` pulses with 8'hA5, 8'h3C, 8'hFF in order; `o_Empty`=1 after the 3rd read.
- Full/overrun (`DEPTH`=8, macro defined): write 9 bytes 8'h00..8'h08 with no reads → `o_Full`=1, `o_Count`=8, `o_Overrun`=1; draining yields 8'h00..8'h07 and 8'h08 is lost. Pulse `i_Clr_Overrun` → `o_Overrun`=0.
- Simultaneous read and write at full: with 8 entries, write and read in the same cycle → read returns the oldest byte, `o_Count` stays 8, `o_Overrun` stays 0, and the new byte is read last.
- Wrap-around: perform 20 write/read pairs with data = index → every readback matches, and pointers wrap past 7 without corruption.
- Empty read: with `i_Rd_En` held high on an empty FIFO for 5 cycles, then one write of 8'h5A → no `o_Rd_Valid` during the 5 cycles; 8'h5A appears with `o_Rd_Valid` exactly 2 edges after the write strobe.
